// File: rtl/axi_wr_sched.sv
// Round-robin AW/W write scheduler over NUM_REQ command FIFOs with per-requester B tracking.
// Optional stall watchdog is compiled in when WR_SCHED_TIMEOUT_EN is defined.
module axi_wr_sched #(
   parameter int unsigned NUM_REQ         = 8,
   parameter int unsigned ADDR_W          = 64,
   parameter int unsigned ID_W            = 8,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned TIMEOUT_CYC     = 1024,
   localparam int unsigned SEL_W          = $clog2(NUM_REQ),
   localparam int unsigned CMD_W          = ADDR_W + 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       cmd_empty,
   input  logic [NUM_REQ*CMD_W-1:0] cmd_data,
   output logic [NUM_REQ-1:0]       cmd_rd,
   output logic                     awvalid,
   input  logic                     awready,
   output logic [ADDR_W-1:0]        awaddr,
   output logic [7:0]               awlen,
   output logic [2:0]               awsize,
   output logic [1:0]               awburst,
   output logic [ID_W-1:0]          awid,
   output logic                     w_active,
   output logic [SEL_W-1:0]         w_sel,
   input  logic                     w_hs,
   output logic                     wlast_exp,
   input  logic                     bvalid,
   input  logic [ID_W-1:0]          bid,
   input  logic [1:0]               bresp,
   output logic                     bready,
   output logic [NUM_REQ-1:0]       req_done,
   output logic [NUM_REQ-1:0]       req_err,
   output logic                     proto_err,
   output logic [3:0]               outstanding,
   output logic                     timeout_err
);

   typedef enum logic [1:0] {StIdle, StAw, StW} state_e;

   state_e           state;
   logic [SEL_W-1:0] rr_ptr;
   logic [SEL_W-1:0] grant_idx;
   logic [SEL_W-1:0] winner;
   logic [SEL_W-1:0] scan_idx;
   logic             found;
   logic             grant;
   logic             aw_hs;
   logic [CMD_W-1:0] head;
   logic [8:0]       beat_cnt;
   logic [3:0]       req_cnt [NUM_REQ];
   logic [SEL_W-1:0] b_idx;
   logic             b_ok;

   assign awburst = 2'b01;
   assign bready  = 1'b1;

   // First non-empty FIFO at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = rr_ptr + SEL_W'(k);
         if (!found && !cmd_empty[scan_idx]) begin
            found  = 1'b1;
            winner = scan_idx;
         end
      end
   end

   assign grant = !reset && (state == StIdle) && found &&
                  (outstanding < 4'(MAX_OUTSTANDING));
   assign head  = cmd_data[int'(winner)*CMD_W +: CMD_W];

   always_comb begin
      cmd_rd = '0;
      if (grant) cmd_rd[winner] = 1'b1;
   end

   assign aw_hs     = (state == StAw) && awready;
   assign wlast_exp = w_active && (beat_cnt == {1'b0, awlen});
   assign b_idx     = bid[SEL_W-1:0];
   assign b_ok      = bvalid && ((bid >> SEL_W) == '0) && (req_cnt[b_idx] != 4'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= StIdle;
         rr_ptr    <= '0;
         grant_idx <= '0;
         awvalid   <= 1'b0;
         awaddr    <= '0;
         awlen     <= '0;
         awsize    <= '0;
         awid      <= '0;
         w_active  <= 1'b0;
         w_sel     <= '0;
         beat_cnt  <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (grant) begin
                  grant_idx <= winner;
                  awid      <= ID_W'(winner);
                  awaddr    <= head[ADDR_W-1:0];
                  awlen     <= head[ADDR_W+7:ADDR_W];
                  awsize    <= head[ADDR_W+10:ADDR_W+8];
                  awvalid   <= 1'b1;
                  state     <= StAw;
               end
            end
            StAw: begin
               if (awready) begin
                  awvalid  <= 1'b0;
                  beat_cnt <= '0;
                  w_active <= 1'b1;
                  w_sel    <= grant_idx;
                  state    <= StW;
               end
            end
            StW: begin
               if (w_hs) begin
                  beat_cnt <= beat_cnt + 9'd1;
                  if (wlast_exp) begin
                     w_active <= 1'b0;
                     rr_ptr   <= grant_idx + SEL_W'(1);
                     state    <= StIdle;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

   // A bad bid or a B for a requester with nothing in flight leaves all counts untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding <= '0;
         req_done    <= '0;
         req_err     <= '0;
         proto_err   <= 1'b0;
         for (int i = 0; i < NUM_REQ; i++) req_cnt[i] <= '0;
      end else begin
         req_done <= '0;
         if (b_ok) begin
            req_done[b_idx] <= 1'b1;
            if (bresp != 2'b00) req_err[b_idx] <= 1'b1;
         end else if (bvalid) begin
            proto_err <= 1'b1;
         end
         if (aw_hs && !b_ok) outstanding <= outstanding + 4'd1;
         else if (b_ok && !aw_hs) outstanding <= outstanding - 4'd1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((aw_hs && grant_idx == SEL_W'(i)) && !(b_ok && b_idx == SEL_W'(i)))
               req_cnt[i] <= req_cnt[i] + 4'd1;
            else if ((b_ok && b_idx == SEL_W'(i)) && !(aw_hs && grant_idx == SEL_W'(i)))
               req_cnt[i] <= req_cnt[i] - 4'd1;
         end
      end
   end

`ifdef WR_SCHED_TIMEOUT_EN
   logic [15:0] stall_cnt;
   logic        stalling;

   // Every state exit is a handshake, so clearing when not stalling covers state changes.
   assign stalling = ((state == StAw) && !awready) || ((state == StW) && !w_hs);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt   <= '0;
         timeout_err <= 1'b0;
      end else if (!stalling) begin
         stall_cnt <= '0;
      end else begin
         if (stall_cnt != 16'hffff) stall_cnt <= stall_cnt + 16'd1;
         if (32'(stall_cnt) + 32'd1 >= 32'(TIMEOUT_CYC)) timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wr_sched.sv
// Randomized scoreboard bench for axi_wr_sched: FIFO/AXI environment plus a rule-level model.
`timescale 1ns/1ps
module tb_axi_wr_sched;

   localparam int NUM_REQ = 8;
   localparam int ADDR_W  = 64;
   localparam int ID_W    = 8;
   localparam int MAXO    = 4;
   localparam int TMO     = 1024;
   localparam int SEL_W   = 3;
   localparam int CMD_W   = ADDR_W + 11;
   localparam int PIDLE = 0, PAW = 1, PW = 2;

   typedef struct packed {
      logic [2:0]  size;
      logic [7:0]  len;
      logic [63:0] addr;
   } cmd_t;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_REQ-1:0]       cmd_empty;
   logic [NUM_REQ*CMD_W-1:0] cmd_data;
   logic [NUM_REQ-1:0]       cmd_rd;
   logic                     awvalid, awready;
   logic [ADDR_W-1:0]        awaddr;
   logic [7:0]               awlen;
   logic [2:0]               awsize;
   logic [1:0]               awburst;
   logic [ID_W-1:0]          awid;
   logic                     w_active, w_hs, wlast_exp;
   logic [SEL_W-1:0]         w_sel;
   logic                     bvalid, bready;
   logic [ID_W-1:0]          bid;
   logic [1:0]               bresp;
   logic [NUM_REQ-1:0]       req_done, req_err;
   logic                     proto_err, timeout_err;
   logic [3:0]               outstanding;

   always #5 clk = ~clk;

   axi_wr_sched #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .ID_W(ID_W),
      .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .reset(reset), .cmd_empty(cmd_empty), .cmd_data(cmd_data), .cmd_rd(cmd_rd),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awid(awid), .w_active(w_active), .w_sel(w_sel), .w_hs(w_hs),
      .wlast_exp(wlast_exp), .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
      .req_done(req_done), .req_err(req_err), .proto_err(proto_err),
      .outstanding(outstanding), .timeout_err(timeout_err)
   );

   int total = 0, bad = 0;

   // Environment and reference model state.
   cmd_t       fifo_q [NUM_REQ][$];
   cmd_t       aw_exp_q [$];
   int         aw_id_q [$];
   int         phase = PIDLE, ptr_m = 0, beat_m = 0, out_m = 0, cur_id = 0, cur_len = 0;
   int         cnt_m [NUM_REQ];
   logic [7:0] err_m = '0, done_exp = '0;
   logic       proto_m = 1'b0;
   int         pop_pend = -1;
   bit         mon_en = 1'b0;

   // Stimulus knobs.
   int         p_aw = 100, p_whs = 100, p_b = 100, p_cmd = 0;
   bit         whs_alt = 0, whs_tog = 0, b_one = 0, b_on_aw = 0;
   int         force_bid = -1;
   logic [1:0] force_resp = 2'b00;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < NUM_REQ; i++) begin
         cmd_empty[i] = (fifo_q[i].size() == 0);
         cmd_data[i*CMD_W +: CMD_W] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
      end
   endtask

   task automatic push_cmd(input int r, input int len);
      cmd_t c;
      c.addr = {$urandom, $urandom};
      c.len  = 8'(len);
      c.size = 3'($urandom_range(0, 7));
      fifo_q[r].push_back(c);
      refresh();
   endtask

   function automatic int pick_valid();
      int s = $urandom_range(0, NUM_REQ - 1);
      for (int k = 0; k < NUM_REQ; k++)
         if (cnt_m[(s + k) % NUM_REQ] > 0) return (s + k) % NUM_REQ;
      return -1;
   endfunction

   task automatic step(input int n);
      int v;
      repeat (n) begin
         @(negedge clk);
         if (pop_pend >= 0) begin
            fifo_q[pop_pend].delete(0);
            pop_pend = -1;
         end
         if ($urandom_range(0, 99) < p_cmd) begin
            v = $urandom_range(0, NUM_REQ - 1);
            if (fifo_q[v].size() < 3)
               push_cmd(v, ($urandom_range(0, 15) == 0) ? $urandom_range(8, 40)
                                                         : $urandom_range(0, 7));
         end
         refresh();
         awready = ($urandom_range(0, 99) < p_aw);
         if (whs_alt) begin
            whs_tog = !whs_tog;
            w_hs    = whs_tog;
         end else begin
            w_hs = ($urandom_range(0, 99) < p_whs);
         end
         bvalid = 1'b0; bid = '0; bresp = 2'b00;
         if (force_bid >= 0) begin
            bvalid = 1'b1; bid = 8'(force_bid); bresp = force_resp; force_bid = -1;
         end else if (b_one || (b_on_aw && awvalid && awready) ||
                      ($urandom_range(0, 99) < p_b)) begin
            v = pick_valid();
            if (v >= 0) begin
               bvalid = 1'b1;
               bid    = 8'(v);
               bresp  = ($urandom_range(0, 7) == 0) ? 2'b10 :
                        ($urandom_range(0, 15) == 0) ? 2'b11 : 2'b00;
               b_one  = 0;
               if (awvalid && awready) b_on_aw = 0;
            end
         end
      end
   endtask

   // Monitor: compare registered/combinational outputs with the model, then advance the model
   // by the handshakes that the coming rising edge will take.
   always begin
      int g, idx, inc, dec;
      @(negedge clk);
      #1;
      if (mon_en) begin
         chk("outstanding", outstanding, out_m);
         chk("awvalid", awvalid, phase == PAW);
         if (phase == PAW) begin
            if (aw_exp_q.size() == 0) begin
               chk("aw_scoreboard_empty", 1, 0);
            end else begin
               chk("awaddr", awaddr, aw_exp_q[0].addr);
               chk("awlen", awlen, aw_exp_q[0].len);
               chk("awsize", awsize, aw_exp_q[0].size);
               chk("awid", awid, aw_id_q[0]);
            end
         end
         chk("awburst", awburst, 2'b01);
         chk("bready", bready, 1'b1);
         chk("w_active", w_active, phase == PW);
         if (phase == PW) chk("w_sel", w_sel, cur_id);
         chk("wlast_exp", wlast_exp, (phase == PW) && (beat_m == cur_len));
         chk("req_done", req_done, done_exp);
         chk("req_err", req_err, err_m);
         chk("proto_err", proto_err, proto_m);
         g = -1;
         if (phase == PIDLE && out_m < MAXO)
            for (int k = 0; k < NUM_REQ; k++)
               if (g < 0 && fifo_q[(ptr_m + k) % NUM_REQ].size() != 0) g = (ptr_m + k) % NUM_REQ;
         chk("cmd_rd", cmd_rd, (g >= 0) ? (64'd1 << g) : 64'd0);

         inc = 0; dec = 0; done_exp = '0;
         if (bvalid) begin
            idx = int'(bid) % NUM_REQ;
            if (int'(bid) < NUM_REQ && cnt_m[idx] > 0) begin
               cnt_m[idx]--;
               dec = 1;
               done_exp[idx] = 1'b1;
               if (bresp != 2'b00) err_m[idx] = 1'b1;
            end else begin
               proto_m = 1'b1;
            end
         end
         if (phase == PIDLE && g >= 0) begin
            aw_exp_q.push_back(fifo_q[g][0]);
            aw_id_q.push_back(g);
            pop_pend = g;
            phase = PAW;
         end else if (phase == PAW && awready && aw_exp_q.size() != 0) begin
            cur_id  = aw_id_q.pop_front();
            cur_len = int'(aw_exp_q.pop_front().len);
            cnt_m[cur_id]++;
            inc = 1;
            beat_m = 0;
            phase = PW;
         end else if (phase == PW && w_hs) begin
            if (beat_m == cur_len) begin
               phase = PIDLE;
               ptr_m = (cur_id + 1) % NUM_REQ;
            end else begin
               beat_m++;
            end
         end
         out_m += inc - dec;
      end
   end

   task automatic check_reset_outputs();
      chk("rst_cmd_rd", cmd_rd, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_awaddr", awaddr, 0);
      chk("rst_awlen", awlen, 0);
      chk("rst_awid", awid, 0);
      chk("rst_awburst", awburst, 2'b01);
      chk("rst_w_active", w_active, 0);
      chk("rst_w_sel", w_sel, 0);
      chk("rst_wlast_exp", wlast_exp, 0);
      chk("rst_bready", bready, 1);
      chk("rst_req_done", req_done, 0);
      chk("rst_req_err", req_err, 0);
      chk("rst_proto_err", proto_err, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_timeout_err", timeout_err, 0);
   endtask

   task automatic reset_model();
      for (int i = 0; i < NUM_REQ; i++) begin
         fifo_q[i].delete();
         cnt_m[i] = 0;
      end
      aw_exp_q.delete(); aw_id_q.delete();
      phase = PIDLE; ptr_m = 0; beat_m = 0; out_m = 0;
      err_m = '0; done_exp = '0; proto_m = 1'b0; pop_pend = -1;
      refresh();
   endtask

   task automatic drain();
      int c = 0;
      p_cmd = 0; p_b = 100; p_aw = 100; p_whs = 100; whs_alt = 0;
      while (c < 4000 && !(phase == PIDLE && out_m == 0 && pop_pend < 0 &&
             fifo_q[0].size() + fifo_q[1].size() + fifo_q[2].size() + fifo_q[3].size() +
             fifo_q[4].size() + fifo_q[5].size() + fifo_q[6].size() + fifo_q[7].size() == 0)) begin
         step(1);
         c++;
      end
      chk("drain_within_budget", c < 4000, 1);
   endtask

   initial begin
      int c;
      reset = 1'b1; awready = 0; w_hs = 0; bvalid = 0; bid = '0; bresp = '0;
      for (int i = 0; i < NUM_REQ; i++) cnt_m[i] = 0;
      refresh();
      repeat (2) @(negedge clk);
      #1 check_reset_outputs();
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Single requester 2, four beats, everything always ready.
      step(1);
      push_cmd(2, 3);
      step(20);
      chk("single_outstanding_back_to_0", outstanding, 0);

      // All FIFOs loaded with single-beat bursts, then 5 alone followed by 3 and 6.
      for (int i = 0; i < NUM_REQ; i++) push_cmd(i, 0);
      push_cmd(0, 0);
      step(60);
      push_cmd(5, 0);
      step(8);
      push_cmd(3, 0);
      push_cmd(6, 0);
      drain();

      // B responses held off: only MAXO AWs may go out, a single B lets one more through.
      p_b = 0;
      for (int i = 0; i < 6; i++) push_cmd(i, 0);
      step(40);
      chk("cap_holds_at_max", outstanding, MAXO);
      b_one = 1;
      step(15);
      chk("cap_refill_after_one_b", outstanding, MAXO);
      drain();

      // 256-beat burst with alternating w_hs; its AW handshake coincides with a B.
      p_b = 0;
      push_cmd(0, 0);
      step(15);
      push_cmd(4, 255);
      b_on_aw = 1; whs_alt = 1;
      step(20);
      chk("aw_and_b_same_cycle", outstanding, 1);
      step(600);
      drain();

      // Randomized traffic with varying response pressure.
      p_cmd = 40; p_aw = 70; p_whs = 70;
      for (int r = 0; r < 6; r++) begin
         p_b = (r % 2 == 0) ? 10 : 60;
         step(400);
      end
      drain();

      // Unexpected bid, then an error response on a legitimate one.
      force_bid = 3; force_resp = 2'b00;
      step(3);
      chk("proto_err_set", proto_err, 1);
      chk("proto_no_underflow", outstanding, 0);
      p_b = 0;
      push_cmd(6, 0);
      step(10);
      force_bid = 6; force_resp = 2'b10;
      step(3);
      chk("req_err6_set", req_err[6], 1);
      step(5);
      chk("req_err6_sticky", req_err[6], 1);

      // Asynchronous reset in the middle of a burst.
      p_b = 100;
      push_cmd(1, 20);
      c = 0;
      while (c < 200 && !(phase == PW && beat_m == 10)) begin
         step(1);
         c++;
      end
      chk("reach_beat_10", c < 200, 1);
      mon_en = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_outputs();
      reset_model();
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
      step(5);

`ifdef WR_SCHED_TIMEOUT_EN
      mon_en = 1'b0;
      p_aw = 0;
      push_cmd(0, 0);
      step(TMO + 10);
      chk("timeout_err_set", timeout_err, 1);
`else
      chk("timeout_err_tied_low", timeout_err, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule

// File: doc/axi_wr_sched.md
Name: axi_wr_sched

Overview:
- Write-side scheduler for the AXI master. Shares the single AW/W channel pair among NUM_REQ command FIFOs using round-robin arbitration.
- Issues one AW per grant, then sequences the W data phase by telling the write datapath which requester's data to drive and when the last beat occurs.
- Tracks outstanding B responses per requester and caps the total in flight.
- Sits between the per-requester AXI-converter command FIFOs and the write-data channel block.

Parameters:
- NUM_REQ, 8, number of requesters (power of 2, ≥2)
- ADDR_W, 64, AXI address width
- ID_W, 8, AXI ID width (≥ log2(NUM_REQ))
- MAX_OUTSTANDING, 4, max AW issued without B, all requesters combined (1..15)
- TIMEOUT_CYC, 1024, stall watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_empty  in  NUM_REQ  per-requester command FIFO empty
- cmd_data  in  NUM_REQ*CMD_W  show-ahead FIFO heads; CMD_W=ADDR_W+11; per slot [ADDR_W-1:0] addr, [ADDR_W+7:ADDR_W] awlen, [ADDR_W+10:ADDR_W+8] awsize
- cmd_rd  out  NUM_REQ  one-hot pop pulse
- awvalid  out  1  AW valid
- awready  in  1  AW ready
- awaddr  out  ADDR_W  AW address
- awlen  out  8  AW burst length
- awsize  out  3  AW beat size
- awburst  out  2  constant 2'b01 (INCR)
- awid  out  ID_W  granted requester index, zero-extended
- w_active  out  1  W phase in progress
- w_sel  out  log2(NUM_REQ)  requester whose data drives W
- w_hs  in  1  wvalid&wready from the datapath
- wlast_exp  out  1  current beat is the last beat
- bvalid  in  1  B valid
- bid  in  ID_W  B ID
- bresp  in  2  B response
- bready  out  1  constant 1
- req_done  out  NUM_REQ  one-cycle pulse per completed B
- req_err  out  NUM_REQ  sticky; bresp≠OKAY seen for that requester
- proto_err  out  1  sticky; unexpected bid
- outstanding  out  4  total AWs in flight
- timeout_err  out  1  sticky stall flag

Behaviour:
- Reset (async, immediate, including mid-burst):
  - All outputs 0 except bready=1 and awburst=01.
  - FSM goes to IDLE; rr_ptr=0; all counters cleared.
- FSM states: IDLE, AW, W.
- IDLE:
  - Eligible requesters are those with !cmd_empty[i]. A grant requires outstanding<MAX_OUTSTANDING.
  - Winner is the first eligible index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - On grant, in the same cycle: cmd_rd[winner]=1 and the head fields are latched into awaddr/awlen/awsize; awid=winner.
  - Next state AW, with awvalid=1 registered (awvalid rises 1 cycle after a non-empty FIFO is seen in IDLE).
  - No eligible requester, or outstanding at cap → stay in IDLE, no pop.
- AW:
  - awvalid and all AW fields are held stable until awready.
  - On the handshake: awvalid→0, outstanding increments, beat_cnt=0, next state W.
- W:
  - w_active=1, w_sel=granted index.
  - wlast_exp = (beat_cnt==awlen), combinational from registers.
  - Each w_hs increments beat_cnt (9-bit; awlen=255 gives 256 beats).
  - w_hs while wlast_exp → next state IDLE, w_active→0, rr_ptr=(grant+1) mod NUM_REQ.
  - w_hs outside W is ignored.
- At most one burst is in AW/W at a time, so W order always matches AW order.
- B channel:
  - On bvalid, idx = bid[log2(NUM_REQ)-1:0].
  - If per-requester count[idx]>0: decrement count[idx] and outstanding; req_done[idx] pulses the next cycle; bresp≠0 sets req_err[idx].
  - If count[idx]==0, or the upper bid bits are nonzero: set proto_err; no counter changes (no underflow).
- AW handshake and B completion in the same cycle → outstanding unchanged; per-requester counts are updated individually.
- Per-requester counters are 4-bit and saturate-safe by construction (cap ≤ 15).
- Outstanding-cap check uses the registered count. A B arriving in the same IDLE cycle frees the slot from the next cycle.

Optional Feature:
- Macro WR_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter runs in AW (no awready) and in W (no w_hs); it clears on any handshake or on state change.
  - Reaching TIMEOUT_CYC sets timeout_err (sticky until reset). The FSM is not aborted.
- Undefined: the counter is absent and timeout_err is tied to 0.

Test Plan:
- Single requester 2, awlen=3, awready/w_hs always 1 → awvalid cycle+1 with awid=2, cmd_rd[2] one pulse, 4 w_hs with wlast_exp on the 4th, bid=2 OKAY → req_done[2] pulse, outstanding 1→0.
- All 8 FIFOs non-empty, awlen=0, rr_ptr=0 → grant order 0,1,…,7,0; after a grant to 5 with only 3 and 6 pending → 6 is granted next.
- bready held off downstream (no bvalid), MAX_OUTSTANDING=4, 6 commands → exactly 4 AWs, IDLE holds; one bvalid → 5th AW is issued.
- awlen=255, w_hs every other cycle → wlast_exp only on beat 256; AW handshake and bvalid on the same cycle → outstanding unchanged.
- bid=3 with count[3]=0 → proto_err=1, outstanding unchanged; bresp=2'b10 for a valid bid → req_err set and sticky.
- reset asserted in W at beat 10 → all outputs return to reset values asynchronously; with WR_SCHED_TIMEOUT_EN, awready held 0 for TIMEOUT_CYC cycles → timeout_err=1.
